// File: rtl/brush_writer.sv
// brush_writer -- write-side engine for the pixel store.
//
// Takes one paint command at a time (center, color, radius) and sweeps the
// (2r+1)x(2r+1) square footprint, one write beat per clock, row by row.
// Beats whose pixel lies off the canvas are suppressed: we=0 and the
// address/data outputs hold. The sweep length depends only on r.
//
// Optional feature, macro BRUSH_CLEAR_EN: when defined, a clear_req seen
// in IDLE sweeps the whole canvas to color 0 in row-major order. The clear
// takes priority over a paint command arriving in the same cycle. When the
// macro is undefined, clear_req is accepted on the port but ignored.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   cmd_valid/ready  paint command handshake (ready only in IDLE)
//   cmd_x, cmd_y     brush center, 0..255 (off-canvas centers are legal)
//   cmd_color        color to paint
//   cmd_radius       brush radius r
//   clear_req        canvas clear request (BRUSH_CLEAR_EN only)
//   we, wx, wy       registered write strobe and address to the store
//   new_color        registered write data
//   busy             a sweep is on the outputs
//   done             pulse on the final beat of a sweep
module brush_writer #(
  parameter int GRID = 128,
  parameter int R_W  = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [7:0]     cmd_x,
  input  logic [7:0]     cmd_y,
  input  logic [2:0]     cmd_color,
  input  logic [R_W-1:0] cmd_radius,
  input  logic           clear_req,
  output logic           we,
  output logic [7:0]     wx,
  output logic [7:0]     wy,
  output logic [2:0]     new_color,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {IDLE, PAINT, CLEAR} state_t;

  localparam logic signed [R_W:0] ONE = 1;
  localparam logic [7:0] LAST = 8'(GRID - 1);

  state_t               state_q, state_d;
  logic [7:0]           cx_q, cx_d, cy_q, cy_d;
  logic [2:0]           color_q, color_d;
  logic [R_W-1:0]       rad_q, rad_d;
  // Offsets of the beat currently on the outputs.
  logic signed [R_W:0]  dx_q, dx_d, dy_q, dy_d;
  logic                 we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic [7:0]           wx_q, wx_d, wy_q, wy_d;
  logic [2:0]           col_q, col_d;

  // Beat generator inputs: either the incoming command (first beat) or the
  // latched command with the advanced offsets.
  logic [7:0]           sel_cx, sel_cy;
  logic [2:0]           sel_col;
  logic signed [R_W:0]  sel_rs, sel_dx, sel_dy, r_s;
  logic                 do_beat;
  logic [9:0]           bx, by;
  logic                 on_x, on_y;

`ifdef BRUSH_CLEAR_EN
  assign cmd_ready = (state_q == IDLE) && !reset && !clear_req;
`else
  assign cmd_ready = (state_q == IDLE) && !reset;
  logic unused_clear;
  assign unused_clear = clear_req;
`endif

  assign r_s = $signed({1'b0, rad_q});

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    color_d = color_q;
    rad_d   = rad_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    we_d    = 1'b0;
    wx_d    = wx_q;
    wy_d    = wy_q;
    col_d   = col_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    sel_cx  = cx_q;
    sel_cy  = cy_q;
    sel_col = color_q;
    sel_rs  = r_s;
    sel_dx  = dx_q;
    sel_dy  = dy_q;
    do_beat = 1'b0;
    bx      = '0;
    by      = '0;
    on_x    = 1'b0;
    on_y    = 1'b0;

    case (state_q)
      IDLE: begin
`ifdef BRUSH_CLEAR_EN
        if (clear_req) begin
          state_d = CLEAR;
          we_d    = 1'b1;
          wx_d    = '0;
          wy_d    = '0;
          col_d   = '0;
          busy_d  = 1'b1;
          done_d  = (GRID == 1);
        end else
`endif
        if (cmd_valid) begin
          state_d = PAINT;
          cx_d    = cmd_x;
          cy_d    = cmd_y;
          color_d = cmd_color;
          rad_d   = cmd_radius;
          sel_cx  = cmd_x;
          sel_cy  = cmd_y;
          sel_col = cmd_color;
          sel_rs  = $signed({1'b0, cmd_radius});
          sel_dx  = -sel_rs;
          sel_dy  = -sel_rs;
          do_beat = 1'b1;
        end
      end
      PAINT: begin
        if (dx_q == r_s && dy_q == r_s) begin
          state_d = IDLE;
        end else begin
          do_beat = 1'b1;
          if (dx_q == r_s) begin
            sel_dx = -r_s;
            sel_dy = dy_q + ONE;
          end else begin
            sel_dx = dx_q + ONE;
          end
        end
      end
`ifdef BRUSH_CLEAR_EN
      // The write address itself is the clear counter: every clear beat
      // writes, so wx/wy always hold the current clear position.
      CLEAR: begin
        if (wx_q == LAST && wy_q == LAST) begin
          state_d = IDLE;
        end else begin
          we_d   = 1'b1;
          busy_d = 1'b1;
          col_d  = '0;
          if (wx_q == LAST) begin
            wx_d = '0;
            wy_d = wy_q + 8'd1;
          end else begin
            wx_d = wx_q + 8'd1;
          end
          done_d = (wx_d == LAST) && (wy_d == LAST);
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (do_beat) begin
      dx_d   = sel_dx;
      dy_d   = sel_dy;
      busy_d = 1'b1;
      done_d = (sel_dx == sel_rs) && (sel_dy == sel_rs);
      // 10-bit two's complement pixel position; negative or >= GRID is off.
      bx   = {2'b00, sel_cx} + {{(9-R_W){sel_dx[R_W]}}, sel_dx};
      by   = {2'b00, sel_cy} + {{(9-R_W){sel_dy[R_W]}}, sel_dy};
      on_x = !bx[9] && (bx[8:0] < 9'(GRID));
      on_y = !by[9] && (by[8:0] < 9'(GRID));
      if (on_x && on_y) begin
        we_d  = 1'b1;
        wx_d  = bx[7:0];
        wy_d  = by[7:0];
        col_d = sel_col;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      color_q <= '0;
      rad_q   <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      we_q    <= 1'b0;
      wx_q    <= '0;
      wy_q    <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      color_q <= color_d;
      rad_q   <= rad_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      we_q    <= we_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      col_q   <= col_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign we        = we_q;
  assign wx        = wx_q;
  assign wy        = wy_q;
  assign new_color = col_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_brush_writer.sv
// Self-checking bench for brush_writer. A reference model built from plain
// loops over the brush square predicts every beat; random commands cover
// on/off-canvas centers and all radii.
module tb_brush_writer;
  logic       clk = 1'b0;
  logic       reset, cmd_valid, cmd_ready, clear_req;
  logic [7:0] cmd_x, cmd_y, wx, wy;
  logic [2:0] cmd_color, new_color;
  logic [1:0] cmd_radius;
  logic       we, busy, done;

  int n_chk = 0;
  int n_err = 0;
  // Model of the last value driven on the write port (held on suppressed beats).
  int         lx = 0, ly = 0;
  logic [2:0] lc = 3'd0;

  brush_writer #(.GRID(128), .R_W(2)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_color(cmd_color),
    .cmd_radius(cmd_radius), .clear_req(clear_req), .we(we), .wx(wx),
    .wy(wy), .new_color(new_color), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [22:0] obs();
    return {we, wx, wy, new_color, busy, done, cmd_ready};
  endfunction

  function automatic logic [22:0] pk(input bit w, input int x, input int y,
                                     input logic [2:0] c, input bit b,
                                     input bit d, input bit rd);
    return {w, 8'(x), 8'(y), c, b, d, rd};
  endfunction

  task automatic present(input int x, input int y, input logic [2:0] c, input int r);
    cmd_x = 8'(x); cmd_y = 8'(y); cmd_color = c; cmd_radius = 2'(r);
    cmd_valid = 1'b1;
  endtask

  // Called in cycle T with the command presented; returns in cycle T+N+1.
  task automatic sweep(input int cx, input int cy, input logic [2:0] c, input int r,
                       input bit keep, input int nx, input int ny,
                       input logic [2:0] nc, input int nr);
    int i = 0;
    int n = (2*r+1) * (2*r+1);
    chk("ready_pre", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    for (int dy = -r; dy <= r; dy++) begin
      for (int dx = -r; dx <= r; dx++) begin
        int x = cx + dx;
        int y = cy + dy;
        bit on = (x >= 0) && (x < 128) && (y >= 0) && (y < 128);
        @(negedge clk);
        i++;
        if (i == 1) begin
          if (keep) present(nx, ny, nc, nr);
          else begin
            cmd_valid = 1'b0;
            cmd_x = 8'($urandom); cmd_y = 8'($urandom);
            cmd_color = 3'($urandom); cmd_radius = 2'($urandom);
          end
        end
        if (on) begin lx = x; ly = y; lc = c; end
        chk("beat", 32'(obs()), 32'(pk(on, lx, ly, lc, 1, i == n, 0)));
      end
    end
    @(negedge clk);
    chk("ready_post", 32'(obs()), 32'(pk(0, lx, ly, lc, 0, 0, 1)));
  endtask

  initial begin
    int x, y, r;
    logic [2:0] c;
    reset = 1'b1; cmd_valid = 1'b0; clear_req = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_color = '0; cmd_radius = '0;
    repeat (3) begin
      @(negedge clk);
      chk("rst", 32'(obs()), 32'd0);
    end
    reset = 1'b0;
    #1 chk("rst_rel", 32'(obs()), 32'(pk(0, 0, 0, 0, 0, 0, 1)));

    present(10, 20, 3'b010, 0);
    sweep(10, 20, 3'b010, 0, 0, 0, 0, 0, 0);

    // Second command held valid across the sweep.
    present(5, 5, 3'b101, 1);
    sweep(5, 5, 3'b101, 1, 1, 40, 60, 3'b011, 2);
    sweep(40, 60, 3'b011, 2, 0, 0, 0, 0, 0);

    present(0, 127, 3'b110, 2);
    sweep(0, 127, 3'b110, 2, 0, 0, 0, 0, 0);

    present(200, 10, 3'b001, 0);
    sweep(200, 10, 3'b001, 0, 0, 0, 0, 0, 0);

    present(127, 0, 3'b111, 3);
    sweep(127, 0, 3'b111, 3, 0, 0, 0, 0, 0);

`ifdef BRUSH_CLEAR_EN
    present(7, 8, 3'b001, 1);
    clear_req = 1'b1;
    #1 chk("clr_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    for (int i = 0; i < 16384; i++) begin
      @(negedge clk);
      if (i == 0) clear_req = 1'b0;
      chk("clear", 32'(obs()), 32'(pk(1, i % 128, i / 128, 0, 1, i == 16383, 0)));
    end
    lx = 127; ly = 127; lc = 3'd0;
    @(negedge clk);
    chk("clr_post", 32'(obs()), 32'(pk(0, lx, ly, lc, 0, 0, 1)));
    sweep(7, 8, 3'b001, 1, 0, 0, 0, 0, 0);
`else
    present(30, 30, 3'b100, 1);
    clear_req = 1'b1;
    sweep(30, 30, 3'b100, 1, 0, 0, 0, 0, 0);
    clear_req = 1'b0;
`endif

    repeat (30) begin
      case ($urandom_range(0, 2))
        0: begin x = $urandom_range(0, 255); y = $urandom_range(0, 255); end
        1: begin x = $urandom_range(0, 3);   y = $urandom_range(124, 131); end
        default: begin x = $urandom_range(124, 131); y = $urandom_range(0, 127); end
      endcase
      r = $urandom_range(0, 3);
      c = 3'($urandom);
      present(x, y, c, r);
      sweep(x, y, c, r, 0, 0, 0, 0, 0);
    end

    // Reset in the middle of an r=1 sweep at (50,50).
    present(50, 50, 3'b111, 1);
    #1 chk("mid_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("mid_beat", 32'(obs()), 32'(pk(1, 49 + i, 49, 3'b111, 1, 0, 0)));
    end
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst", 32'(obs()), 32'd0);
    end
    reset = 1'b0;
    lx = 0; ly = 0; lc = 3'd0;
    #1 chk("mid_rel", 32'(obs()), 32'(pk(0, 0, 0, 0, 0, 0, 1)));
    present(100, 3, 3'b010, 2);
    sweep(100, 3, 3'b010, 2, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/brush_writer.md
# brush_writer

Write-side engine for the 128×128 pixel store. Accepts one paint command at a time (center coordinate, color, brush radius) and sweeps the square brush footprint, driving exactly one write beat per clock onto the store's write port (`wx`, `wy`, `new_color`, `we`). Beats that fall off the canvas are suppressed. An optional clear engine sweeps the whole canvas to the erase color. Sits between the input-decode logic and the pixel store.

## Interface
- `GRID`, default 128: canvas edge length in pixels; addresses are 0..GRID-1.
- `R_W`, default 2: width of the radius field; maximum radius is 2^R_W-1.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `cmd_valid`  in  1  paint command present.
- `cmd_ready`  out  1  engine idle; handshake completes when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_x`, `cmd_y`  in  8 each  brush center, unsigned 0..255.
- `cmd_color`  in  3  color code to paint.
- `cmd_radius`  in  R_W  brush radius r.
- `clear_req`  in  1  canvas-clear request; used only when `BRUSH_CLEAR_EN` is defined.
- `we`  out  1  write strobe to the pixel store.
- `wx`, `wy`  out  8 each  write address; bit 7 is always 0.
- `new_color`  out  3  write data.
- `busy`  out  1  a sweep is in progress.
- `done`  out  1  one-cycle pulse on the final beat of a sweep.

## Operation
- FSM states: IDLE, PAINT, CLEAR.
- `cmd_ready` is 1 only in IDLE and with `reset` low.
- **IDLE → PAINT** on handshake. Center, color, and radius are latched; later input changes have no effect.
- **PAINT** sweeps N = (2r+1)² beats:
  - outer loop dy = -r..+r, inner loop dx = -r..+r;
  - x = cmd_x+dx, y = cmd_y+dy, computed as 10-bit signed.
- **Per beat:**
  - if 0 ≤ x < GRID and 0 ≤ y < GRID: `we`=1, `wx`=x, `wy`=y, `new_color`=latched color;
  - otherwise `we`=0 and `wx`/`wy`/`new_color` hold their previous values;
  - a suppressed beat still consumes its cycle, so latency depends only on r.
- A center outside the canvas is legal. For example, cmd_x=200 with r=0 gives one suppressed beat, and `done` still pulses.
- **PAINT → IDLE** after beat N.
- **IDLE → CLEAR** when `clear_req`=1, with the macro defined:
  - `clear_req` has priority over `cmd_valid` in the same cycle;
  - `cmd_ready` is deasserted that cycle, so no handshake occurs.
- **CLEAR** runs GRID² beats:
  - row-major order: (0,0),(1,0)…(GRID-1,0),(0,1)…(GRID-1,GRID-1);
  - `we`=1 and `new_color`=3'b000 on every beat;
  - returns to IDLE after the last beat.
- `clear_req` is ignored outside IDLE and is not queued.
- **Reset** (any state, including mid-sweep):
  - next state is IDLE; the sweep is aborted and no further beats are issued;
  - `we`=0, `wx`=0, `wy`=0, `new_color`=0, `busy`=0, `done`=0;
  - `cmd_ready`=0 while `reset` is high.

## Timing
- All write-port outputs and `busy`/`done` are registered. `cmd_ready` is decoded from the state register.
- Handshake sampled at the end of cycle T:
  - beat i (1..N) is on the outputs during cycle T+i;
  - `busy`=1 in cycles T+1..T+N;
  - `done`=1 only in cycle T+N;
  - `cmd_ready`=0 in T+1..T+N and 1 again in T+N+1.
- There is at most one accepted command per N+1 cycles. A command held valid through a sweep is accepted in cycle T+N+1.
- Clear latency is GRID² beats with the same framing; GRID=128 gives 16384 beats.
- The store is written on the clock edge that ends each beat cycle.
- Reset release: `cmd_ready`=1 in the first cycle with `reset` low.

## Configuration
- `BRUSH_CLEAR_EN`:
  - **defined:** CLEAR state and full-canvas sweep are present; `clear_req` is honoured as above.
  - **undefined:** the CLEAR state and its address counter are not compiled. The `clear_req` port remains but is ignored, and only PAINT sweeps occur.

## Test plan
1. Reset for 3 cycles, then release -> all outputs 0 during reset; `cmd_ready`=1 in the first cycle after release, `busy`=0.
2. Command (10,20), color 3'b010, r=0 -> one beat `we`=1, `wx`=10, `wy`=20, `new_color`=3'b010, `done`=1 in the same cycle; `cmd_ready`=1 on the next cycle.
3. Command (5,5), r=1 -> 9 beats in order (4,4),(5,4),(6,4),(4,5),(5,5),(6,5),(4,6),(5,6),(6,6), all with `we`=1; `done` on beat 9; a second command held valid is accepted in cycle T+10.
4. Command (0,127), r=2 -> 25 beats; `we`=1 only for x∈{0,1,2}, y∈{125,126,127} (9 writes); 16 suppressed beats; `done` on beat 25.
5. With the macro defined, `clear_req` and `cmd_valid` both high in IDLE -> CLEAR wins and the command is not accepted. Result: 16384 beats color 0, first (0,0), last (127,127) with `done`. The command is then accepted in cycle T+16385.
6. Assert `reset` during beat 3 of an r=1 sweep -> `we`=0 and `busy`=0 from the next cycle, no further beats, `cmd_ready`=1 after release.
